// File: rtl/seq_generator.sv
// Serial pattern transmitter: shifts a latched WIDTH-bit pattern out MSB-first, repeat_cnt+1 frames, GAP idle cycles between.
// Latency: accept at edge k puts the first bit on x in cycle k+1; done pulses the cycle after the final bit.
// Backpressure: none downstream; upstream start is only accepted while ready (IDLE); abort cancels an active transfer.
module seq_generator #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic             abort,
    output logic             ready,
    output logic             x,
    output logic             x_valid,
    output logic             last,
    output logic             done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    localparam int              BW       = $clog2(WIDTH);
    localparam logic [BW-1:0]   BIT_LAST = BW'(WIDTH - 1);
    localparam logic [BW-1:0]   BIT_PEN  = BW'(WIDTH - 2);

    logic [1:0]       state;
    logic [WIDTH-1:0] pat_q;      // latched pattern, used to reload each frame
    logic [WIDTH-1:0] shreg;      // remaining bits of the current frame, next bit at MSB
    logic [BW-1:0]    bit_cnt;    // index of the bit currently on x within the frame
    logic [CNT_W-1:0] frame_cnt;  // frames still to send after the current one
    logic             gap_end;    // final idle cycle of the inter-frame gap

    assign ready = (state == S_IDLE);

    generate
        if (GAP > 0) begin : g_gap
            localparam int GW = $clog2(GAP + 1);
            logic [GW-1:0] gap_cnt;

            assign gap_end = (gap_cnt == GW'(GAP - 1));

            // Count idle cycles while in GAP; cleared whenever GAP is left or not yet entered.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    gap_cnt <= '0;
                end else if (state == S_GAP && !abort && !gap_end) begin
                    gap_cnt <= gap_cnt + 1'b1;
                end else begin
                    gap_cnt <= '0;
                end
            end
        end else begin : g_no_gap
            // GAP state is never entered in this build.
            assign gap_end = 1'b1;
        end
    endgenerate

    // Transfer FSM with registered serial outputs; abort takes priority over frame completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            pat_q     <= '0;
            shreg     <= '0;
            bit_cnt   <= '0;
            frame_cnt <= '0;
            x         <= 1'b0;
            x_valid   <= 1'b0;
            last      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pat_q     <= pattern;
                        frame_cnt <= repeat_cnt;
                        x         <= pattern[WIDTH-1];
                        x_valid   <= 1'b1;
                        last      <= 1'b0;
                        shreg     <= {pattern[WIDTH-2:0], 1'b0};
                        bit_cnt   <= '0;
                        state     <= S_SHIFT;
                    end
                end

                S_SHIFT: begin
                    if (abort) begin
                        state   <= S_IDLE;
                        x       <= 1'b0;
                        x_valid <= 1'b0;
                        last    <= 1'b0;
                    end else if (bit_cnt == BIT_LAST) begin
                        if (frame_cnt == '0) begin
                            state   <= S_IDLE;
                            x       <= 1'b0;
                            x_valid <= 1'b0;
                            last    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            frame_cnt <= frame_cnt - 1'b1;
                            bit_cnt   <= '0;
                            if (GAP > 0) begin
                                state   <= S_GAP;
                                x       <= 1'b0;
                                x_valid <= 1'b0;
                                last    <= 1'b0;
                            end else begin
                                // Next frame starts with no bubble.
                                x       <= pat_q[WIDTH-1];
                                x_valid <= 1'b1;
                                last    <= 1'b0;
                                shreg   <= {pat_q[WIDTH-2:0], 1'b0};
                            end
                        end
                    end else begin
                        x       <= shreg[WIDTH-1];
                        shreg   <= {shreg[WIDTH-2:0], 1'b0};
                        bit_cnt <= bit_cnt + 1'b1;
                        last    <= (bit_cnt == BIT_PEN);
                    end
                end

                S_GAP: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (gap_end) begin
                        state   <= S_SHIFT;
                        x       <= pat_q[WIDTH-1];
                        x_valid <= 1'b1;
                        last    <= 1'b0;
                        shreg   <= {pat_q[WIDTH-2:0], 1'b0};
                        bit_cnt <= '0;
                    end
                end

                default: begin
                    state   <= S_IDLE;
                    x       <= 1'b0;
                    x_valid <= 1'b0;
                    last    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_generator.sv
// Self-checking bench for seq_generator: GAP=1 instance plus a GAP=0 instance.
// Expected per-cycle output streams are built from frame/gap/done rules.
module tb_seq_generator;

    logic       clk;
    logic       reset;

    logic       start, abort;
    logic [3:0] pattern, repeat_cnt;
    logic       ready, x, x_valid, last, done;

    logic       start0, abort0;
    logic [3:0] pattern0, repeat0;
    logic       ready0, x0, x_valid0, last0, done0;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    // Expected vectors {ready, x_valid, x, last, done}, one per cycle after accept.
    logic [4:0] exp_q[$];

    seq_generator #(.WIDTH(4), .CNT_W(4), .GAP(1)) dut (
        .clk(clk), .reset(reset), .start(start), .pattern(pattern),
        .repeat_cnt(repeat_cnt), .abort(abort), .ready(ready), .x(x),
        .x_valid(x_valid), .last(last), .done(done)
    );

    seq_generator #(.WIDTH(4), .CNT_W(4), .GAP(0)) dut_g0 (
        .clk(clk), .reset(reset), .start(start0), .pattern(pattern0),
        .repeat_cnt(repeat0), .abort(abort0), .ready(ready0), .x(x0),
        .x_valid(x_valid0), .last(last0), .done(done0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] obs(input bit sel);
        return sel ? {ready0, x_valid0, x0, last0, done0}
                   : {ready, x_valid, x, last, done};
    endfunction

    task automatic drive(input bit sel, input logic st, input logic [3:0] p,
                         input logic [3:0] r, input logic ab);
        if (sel) begin
            start0 = st; pattern0 = p; repeat0 = r; abort0 = ab;
        end else begin
            start = st; pattern = p; repeat_cnt = r; abort = ab;
        end
    endtask

    // Frames of MSB-first bits, gap idles between frames, then one done cycle in IDLE.
    task automatic build_stream(input logic [3:0] p, input int r, input int gap);
        for (int f = 0; f <= r; f++) begin
            for (int b = 3; b >= 0; b--)
                exp_q.push_back({1'b0, 1'b1, p[b], (b == 0), 1'b0});
            if (f < r)
                for (int g = 0; g < gap; g++)
                    exp_q.push_back(5'b00000);
        end
        exp_q.push_back(5'b10001);
    endtask

    task automatic run_xfer(input string name, input bit sel, input logic [3:0] p,
                            input int r, input int abort_idx);
        logic [4:0] o;
        exp_q.delete();
        build_stream(p, r, sel ? 0 : 1);
        if (abort_idx >= 0) begin
            while (exp_q.size() > abort_idx + 1) void'(exp_q.pop_back());
            exp_q.push_back(5'b10000);
        end
        @(negedge clk);
        o = obs(sel);
        tot_cnt++;
        if (o !== 5'b10000) $display("FAIL %s pre_idle: got %b want %b", name, o, 5'b10000);
        else pass_cnt++;
        drive(sel, 1'b1, p, 4'(r), 1'b0);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            o = obs(sel);
            tot_cnt++;
            if (o !== exp_q[i]) $display("FAIL %s cyc%0d: got %b want %b", name, i, o, exp_q[i]);
            else pass_cnt++;
            // Busy cycles get random start and input churn; it must have no effect.
            drive(sel, (exp_q[i][4] == 1'b0) ? 1'($urandom % 2) : 1'b0,
                  4'($urandom), 4'($urandom), (i == abort_idx));
        end
        @(negedge clk);
        drive(sel, 1'b0, 4'($urandom), 4'($urandom), 1'b0);
        o = obs(sel);
        tot_cnt++;
        if (o !== 5'b10000) $display("FAIL %s post_idle: got %b want %b", name, o, 5'b10000);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        #12;
        tot_cnt++;
        if (obs(0) !== 5'b10000) $display("FAIL reset_main: got %b want %b", obs(0), 5'b10000);
        else pass_cnt++;
        tot_cnt++;
        if (obs(1) !== 5'b10000) $display("FAIL reset_g0: got %b want %b", obs(1), 5'b10000);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        tot_cnt++;
        if (obs(0) !== 5'b10000) $display("FAIL reset_release: got %b want %b", obs(0), 5'b10000);
        else pass_cnt++;
    endtask

    task automatic test_single();
        run_xfer("single_1101", 0, 4'b1101, 0, -1);
    endtask

    task automatic test_repeat();
        run_xfer("repeat_1011", 0, 4'b1011, 2, -1);
        run_xfer("repeat_max", 0, 4'($urandom), 15, -1);
    endtask

    task automatic test_back_to_back(input string name, input logic [3:0] pa, input int ra,
                                     input logic [3:0] pb, input int rb);
        int len_a;
        logic [4:0] o;
        exp_q.delete();
        build_stream(pa, ra, 1);
        len_a = exp_q.size();
        build_stream(pb, rb, 1);
        @(negedge clk);
        o = obs(0);
        tot_cnt++;
        if (o !== 5'b10000) $display("FAIL %s pre_idle: got %b want %b", name, o, 5'b10000);
        else pass_cnt++;
        drive(0, 1'b1, pa, 4'(ra), 1'b0);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            o = obs(0);
            tot_cnt++;
            if (o !== exp_q[i]) $display("FAIL %s cyc%0d: got %b want %b", name, i, o, exp_q[i]);
            else pass_cnt++;
            // Start held high with the second request until it is taken in the done cycle.
            if (i < len_a) drive(0, 1'b1, pb, 4'(rb), 1'b0);
            else           drive(0, 1'b0, 4'($urandom), 4'($urandom), 1'b0);
        end
        @(negedge clk);
        o = obs(0);
        tot_cnt++;
        if (o !== 5'b10000) $display("FAIL %s post_idle: got %b want %b", name, o, 5'b10000);
        else pass_cnt++;
    endtask

    task automatic test_abort();
        run_xfer("abort_bit2", 0, 4'($urandom), 3, 1);
        run_xfer("after_abort", 0, 4'b1001, 1, -1);
        // Final bit of final frame: abort wins, no done.
        run_xfer("abort_final", 0, 4'b0111, 0, 3);
        // Abort during the inter-frame gap.
        run_xfer("abort_gap", 0, 4'b1010, 1, 4);
    endtask

    task automatic test_reset_mid();
        logic [4:0] o;
        @(negedge clk);
        drive(0, 1'b1, 4'b1111, 4'd2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(0, 1'b0, 4'($urandom), 4'($urandom), 1'b0);
            o = obs(0);
            tot_cnt++;
            if (o !== 5'b01100) $display("FAIL rstmid_bit%0d: got %b want %b", i, o, 5'b01100);
            else pass_cnt++;
        end
        #1 reset = 1'b1;
        drive(0, 1'b1, 4'b1111, 4'd0, 1'b0);
        #1;
        o = obs(0);
        tot_cnt++;
        if (o !== 5'b10000) $display("FAIL rstmid_immediate: got %b want %b", o, 5'b10000);
        else pass_cnt++;
        @(negedge clk);
        o = obs(0);
        tot_cnt++;
        if (o !== 5'b10000) $display("FAIL rstmid_held: got %b want %b", o, 5'b10000);
        else pass_cnt++;
        drive(0, 1'b0, 4'd0, 4'd0, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            o = obs(0);
            tot_cnt++;
            if (o !== 5'b10000) $display("FAIL rstmid_after%0d: got %b want %b", i, o, 5'b10000);
            else pass_cnt++;
        end
    endtask

    task automatic test_gap0();
        run_xfer("gap0_1111", 1, 4'b1111, 1, -1);
        for (int n = 0; n < 5; n++)
            run_xfer("gap0_rand", 1, 4'($urandom), $urandom_range(0, 3), -1);
        run_xfer("gap0_abort", 1, 4'b1100, 2, 5);
    endtask

    task automatic test_random();
        int r, len, ab;
        for (int n = 0; n < 25; n++) begin
            r   = $urandom_range(0, 3);
            len = 4 * (r + 1) + r + 1;
            ab  = ($urandom % 4 == 0) ? $urandom_range(0, len - 2) : -1;
            run_xfer("rand", 0, 4'($urandom), r, ab);
        end
        for (int n = 0; n < 4; n++)
            test_back_to_back("rand_b2b", 4'($urandom), $urandom_range(0, 2),
                              4'($urandom), $urandom_range(0, 2));
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 1'b0, 4'd0, 4'd0, 1'b0);
        drive(1, 1'b0, 4'd0, 4'd0, 1'b0);
        test_reset();
        test_single();
        test_repeat();
        test_back_to_back("b2b_1101_0110", 4'b1101, 0, 4'b0110, 0);
        test_abort();
        test_reset_mid();
        test_gap0();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
